// File: rtl/bus_arbiter.sv
// Two-master arbiter that shares one memory port between an instruction bus and a data bus.
// Supports round-robin or data-bus-priority conflict resolution. Each transfer ends with a one-cycle ready pulse.
module bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ib_addr,
    input  logic        ib_valid,
    output logic [31:0] ib_dout,
    output logic        ib_ready,
    input  logic [31:0] db_addr,
    input  logic [3:0]  db_lanes,
    input  logic [31:0] db_din,
    input  logic        db_wr,
    input  logic        db_valid,
    output logic [31:0] db_dout,
    output logic        db_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_lanes,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        grant_db
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_owner_db;
    logic   r_last_db;
    logic   w_grant;
    logic   w_pick_db;
    logic   w_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ib_valid || db_valid) w_state_next = S_MEM;
            S_MEM:   if (mem_ready) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant decision: on conflict, round-robin favours whoever was not granted last
    always_comb begin
        w_grant   = 1'b0;
        w_done    = 1'b0;
        w_pick_db = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant   = ib_valid || db_valid;
            w_pick_db = db_valid && (!ib_valid || (ROUND_ROBIN ? !r_last_db : 1'b1));
        end
        if (r_state == S_MEM) begin
            w_done = mem_ready;
        end
    end

    // Registered memory port, completion data and ready pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_db <= 1'b0;
            r_last_db  <= 1'b0;
            grant_db   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= AW'(0);
            mem_lanes  <= LW'(0);
            mem_wdata  <= DW'(0);
            ib_ready   <= 1'b0;
            db_ready   <= 1'b0;
            ib_dout    <= DW'(0);
            db_dout    <= DW'(0);
        end else begin
            ib_ready <= 1'b0;
            db_ready <= 1'b0;
            if (w_grant) begin
                r_owner_db <= w_pick_db;
                r_last_db  <= w_pick_db;
                grant_db   <= w_pick_db;
                mem_valid  <= 1'b1;
                mem_addr   <= w_pick_db ? db_addr : ib_addr;
                mem_lanes  <= w_pick_db ? db_lanes : LW'(4'hF);
                mem_wdata  <= w_pick_db ? db_din : DW'(0);
                mem_wr     <= w_pick_db ? db_wr : 1'b0;
            end
            if (w_done) begin
                mem_valid <= 1'b0;
                if (r_owner_db) begin
                    db_dout  <= mem_rdata;
                    db_ready <= 1'b1;
                end else begin
                    ib_dout  <= mem_rdata;
                    ib_ready <= 1'b1;
                end
            end
        end
    end

endmodule
